// File: rtl/wash_controller.sv
// ----------------------------------------------------------------------------
// wash_controller
//   Washing-machine sequencer: FILL -> SHAKE -> DRAIN repeated (rinses+1)
//   times, then SPIN -> DONE. Phase lengths come from an internal timer.
//   A fill that never sees the drum full within FILL_TIMEOUT cycles lands
//   in FAULT, which is left only through reset_n.
//
// Optional feature macro: WASH_PAUSE_EN
//   When defined, adds input `pause`. While pause=1 in FILL/SHAKE/DRAIN/SPIN
//   the state, timer and pass counter freeze, the actuators are forced off
//   and busy stays high.
//
// Ports:
//   clock       in   system clock, rising edge
//   reset_n     in   asynchronous active-low reset
//   start       in   begin a program (sampled only in IDLE)
//   full        in   drum-full level sensor
//   dry         in   drum-dry sensor, ends SPIN early
//   rinses      in   extra rinse passes, latched on start
//   valve       out  water inlet open
//   drain       out  drain pump on
//   shake_mode  out  agitate motor
//   turn_mode   out  spin motor
//   busy        out  program in progress
//   done        out  one-cycle completion pulse
//   fault       out  fill timeout, sticky
//   pause       in   (WASH_PAUSE_EN only) freeze the active phase
// ----------------------------------------------------------------------------
module wash_controller #(
    parameter int unsigned CNT_W        = 8,
    parameter int unsigned SHAKE_TICKS  = 8,
    parameter int unsigned SPIN_TICKS   = 6,
    parameter int unsigned FILL_TIMEOUT = 20,
    parameter int unsigned RINSE_W      = 2
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               start,
    input  logic               full,
    input  logic               dry,
    input  logic [RINSE_W-1:0] rinses,
    output logic               valve,
    output logic               drain,
    output logic               shake_mode,
    output logic               turn_mode,
    output logic               busy,
    output logic               done,
    output logic               fault
`ifdef WASH_PAUSE_EN
    ,
    input  logic               pause
`endif
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_SHAKE,
        S_DRAIN,
        S_SPIN,
        S_DONE,
        S_FAULT
    } state_t;

    localparam logic [CNT_W-1:0] FILL_LAST  = CNT_W'(FILL_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] SHAKE_LAST = CNT_W'(SHAKE_TICKS - 1);
    localparam logic [CNT_W-1:0] SPIN_LAST  = CNT_W'(SPIN_TICKS - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   timer_q, timer_d;
    logic [RINSE_W-1:0] pass_q,  pass_d;
    logic [RINSE_W-1:0] rin_q,   rin_d;
    logic               frozen;

`ifdef WASH_PAUSE_EN
    // Pause only acts on the four working phases.
    assign frozen = pause && ((state_q == S_FILL) || (state_q == S_SHAKE) ||
                              (state_q == S_DRAIN) || (state_q == S_SPIN));
`else
    assign frozen = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            timer_q <= '0;
            pass_q  <= '0;
            rin_q   <= '0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            pass_q  <= pass_d;
            rin_q   <= rin_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        pass_d  = pass_q;
        rin_d   = rin_q;
        if (!frozen) begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_FILL;
                        rin_d   = rinses;
                        pass_d  = '0;
                    end
                end
                S_FILL: begin
                    // full has priority over the timeout on the same cycle
                    if (full)                    state_d = S_SHAKE;
                    else if (timer_q == FILL_LAST) state_d = S_FAULT;
                end
                S_SHAKE: begin
                    if (timer_q == SHAKE_LAST) state_d = S_DRAIN;
                end
                S_DRAIN: begin
                    if (!full) begin
                        if (pass_q == rin_q) begin
                            state_d = S_SPIN;
                        end else begin
                            state_d = S_FILL;
                            pass_d  = pass_q + 1'b1;
                        end
                    end
                end
                S_SPIN: begin
                    if (dry || (timer_q == SPIN_LAST)) state_d = S_DONE;
                end
                S_DONE:  state_d = S_IDLE;
                S_FAULT: state_d = S_FAULT;
                default: state_d = S_IDLE;
            endcase
        end

        if (frozen)                 timer_d = timer_q;
        else if (state_d != state_q) timer_d = '0;
        else                         timer_d = timer_q + 1'b1;
    end

    // Moore output decode; pause only masks the actuators
    always_comb begin
        valve      = 1'b0;
        drain      = 1'b0;
        shake_mode = 1'b0;
        turn_mode  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        fault      = 1'b0;
        unique case (state_q)
            S_FILL:  begin valve = 1'b1;      busy = 1'b1; end
            S_SHAKE: begin shake_mode = 1'b1; busy = 1'b1; end
            S_DRAIN: begin drain = 1'b1;      busy = 1'b1; end
            S_SPIN:  begin turn_mode = 1'b1;  drain = 1'b1; busy = 1'b1; end
            S_DONE:  begin done = 1'b1;       busy = 1'b1; end
            S_FAULT: fault = 1'b1;
            default: ;
        endcase
        if (frozen) begin
            valve      = 1'b0;
            drain      = 1'b0;
            shake_mode = 1'b0;
            turn_mode  = 1'b0;
        end
    end

endmodule

// File: tb/tb_wash_controller.sv
// ----------------------------------------------------------------------------
// tb_wash_controller
//   Programs are described at wash-cycle level (rinse count, how long each
//   fill waits for full, how long each drain waits, when the drum goes dry).
//   From that description the bench builds a per-cycle list of sensor inputs
//   together with the output pattern each cycle must show, then replays it.
// ----------------------------------------------------------------------------
module tb_wash_controller;

    localparam int FT  = 20;
    localparam int ST  = 8;
    localparam int SPT = 6;

    // Output vector order: {valve, drain, shake_mode, turn_mode, busy, done, fault}
    localparam logic [6:0] O_IDLE   = 7'b0000000;
    localparam logic [6:0] O_FILL   = 7'b1000100;
    localparam logic [6:0] O_SHAKE  = 7'b0010100;
    localparam logic [6:0] O_DRAIN  = 7'b0100100;
    localparam logic [6:0] O_SPIN   = 7'b0101100;
    localparam logic [6:0] O_DONE   = 7'b0000110;
    localparam logic [6:0] O_FAULT  = 7'b0000001;
    localparam logic [6:0] O_PAUSED = 7'b0000100;

    logic       clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       start = 1'b0;
    logic       full = 1'b0;
    logic       dry = 1'b0;
    logic [1:0] rinses = 2'd0;
    logic       valve, drain, shake_mode, turn_mode, busy, done, fault;
`ifdef WASH_PAUSE_EN
    logic       pause = 1'b0;
`endif

    int vectors = 0;
    int miscompares = 0;

    always #5 clock = ~clock;

    wash_controller #(
        .CNT_W       (8),
        .SHAKE_TICKS (ST),
        .SPIN_TICKS  (SPT),
        .FILL_TIMEOUT(FT),
        .RINSE_W     (2)
    ) dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .start      (start),
        .full       (full),
        .dry        (dry),
        .rinses     (rinses),
        .valve      (valve),
        .drain      (drain),
        .shake_mode (shake_mode),
        .turn_mode  (turn_mode),
        .busy       (busy),
        .done       (done),
        .fault      (fault)
`ifdef WASH_PAUSE_EN
        ,
        .pause      (pause)
`endif
    );

    typedef struct packed {
        logic       st;
        logic       fl;
        logic       dr;
        logic       pse;
        logic [1:0] rin;
        logic [6:0] exp;
    } cyc_t;

    cyc_t trace[$];

    // Program description
    int p_nidle;
    int p_r;
    int p_rin_after;   // -1: random rinses after the start cycle
    int p_fd[4];       // cycles of full=0 before full=1 in each fill; >= FT means timeout
    int p_dd[4];       // cycles of full=1 before full=0 in each drain
    int p_sp;          // SPIN cycle index on which dry=1; >= SPT means never
    int p_fault_cycles;
    int p_done_start;  // start level during DONE (-1 random)
`ifdef WASH_PAUSE_EN
    int p_pause_pct;
    int p_shake_pause;
`endif

    function automatic logic rbit();
        return 1'($urandom_range(1));
    endfunction

    function automatic logic [1:0] rin_val();
        if (p_rin_after < 0) return 2'($urandom_range(3));
        return 2'(p_rin_after);
    endfunction

    task automatic push(input logic s, input logic f, input logic d,
                        input logic [1:0] r, input logic [6:0] e);
        cyc_t c;
        c.st = s; c.fl = f; c.dr = d; c.pse = 1'b0; c.rin = r; c.exp = e;
        trace.push_back(c);
    endtask

    task automatic push_paused(input int n);
        cyc_t c;
        for (int i = 0; i < n; i++) begin
            c.st = rbit(); c.fl = rbit(); c.dr = rbit(); c.pse = 1'b1;
            c.rin = 2'($urandom_range(3)); c.exp = O_PAUSED;
            trace.push_back(c);
        end
    endtask

    // Random pause bursts ahead of a working-phase cycle; they stretch the
    // phase without consuming any of its time.
    task automatic maybe_pause();
`ifdef WASH_PAUSE_EN
        if ($urandom_range(99) < p_pause_pct) push_paused($urandom_range(1, 2));
`endif
    endtask

    task automatic set_defaults();
        p_nidle = 1; p_r = 0; p_rin_after = -1; p_sp = SPT;
        p_fault_cycles = 3; p_done_start = 0;
        for (int i = 0; i < 4; i++) begin p_fd[i] = 0; p_dd[i] = 0; end
`ifdef WASH_PAUSE_EN
        p_pause_pct = 0; p_shake_pause = 0;
`endif
    endtask

    // Returns 1 if the program ends in FAULT.
    task automatic build(output bit faulted);
        faulted = 1'b0;
        trace.delete();
        for (int i = 0; i < p_nidle; i++) push(1'b0, rbit(), rbit(), rin_val(), O_IDLE);
        push(1'b1, rbit(), rbit(), 2'(p_r), O_IDLE);
        for (int p = 0; p <= p_r; p++) begin
            if (p_fd[p] < FT) begin
                for (int i = 0; i < p_fd[p]; i++) begin
                    maybe_pause(); push(rbit(), 1'b0, rbit(), rin_val(), O_FILL);
                end
                maybe_pause(); push(rbit(), 1'b1, rbit(), rin_val(), O_FILL);
            end else begin
                for (int i = 0; i < FT; i++) begin
                    maybe_pause(); push(rbit(), 1'b0, rbit(), rin_val(), O_FILL);
                end
                for (int i = 0; i < p_fault_cycles; i++)
                    push(1'(i % 2 == 0), rbit(), rbit(), rin_val(), O_FAULT);
                faulted = 1'b1;
                return;
            end
            for (int i = 0; i < ST; i++) begin
`ifdef WASH_PAUSE_EN
                if (i == 3) push_paused(p_shake_pause);
`endif
                maybe_pause(); push(rbit(), rbit(), rbit(), rin_val(), O_SHAKE);
            end
            for (int i = 0; i < p_dd[p]; i++) begin
                maybe_pause(); push(rbit(), 1'b1, rbit(), rin_val(), O_DRAIN);
            end
            maybe_pause(); push(rbit(), 1'b0, rbit(), rin_val(), O_DRAIN);
        end
        if (p_sp < SPT) begin
            for (int i = 0; i < p_sp; i++) begin
                maybe_pause(); push(rbit(), rbit(), 1'b0, rin_val(), O_SPIN);
            end
            maybe_pause(); push(rbit(), rbit(), 1'b1, rin_val(), O_SPIN);
        end else begin
            for (int i = 0; i < SPT; i++) begin
                maybe_pause(); push(rbit(), rbit(), 1'b0, rin_val(), O_SPIN);
            end
        end
        push((p_done_start < 0) ? rbit() : 1'(p_done_start), rbit(), rbit(),
             rin_val(), O_DONE);
    endtask

    task automatic play(input string name);
        logic [6:0] got;
        for (int k = 0; k < trace.size(); k++) begin
            @(negedge clock);
            got = {valve, drain, shake_mode, turn_mode, busy, done, fault};
            vectors++;
            if (got !== trace[k].exp) begin
                miscompares++;
                $display("FAIL %s cycle %0d: outputs %b, expected %b", name, k, got, trace[k].exp);
            end
            start  = trace[k].st;
            full   = trace[k].fl;
            dry    = trace[k].dr;
            rinses = trace[k].rin;
`ifdef WASH_PAUSE_EN
            pause  = trace[k].pse;
`endif
        end
    endtask

    task automatic check_now(input string name, input logic [6:0] e);
        logic [6:0] got;
        got = {valve, drain, shake_mode, turn_mode, busy, done, fault};
        vectors++;
        if (got !== e) begin
            miscompares++;
            $display("FAIL %s: outputs %b, expected %b", name, got, e);
        end
    endtask

    // Asynchronous reset between edges, then release and confirm IDLE.
    task automatic do_reset(input string name);
        #2;
        reset_n = 1'b0;
        #1;
        check_now({name, "_async"}, O_IDLE);
        start = 1'b0;
`ifdef WASH_PAUSE_EN
        pause = 1'b0;
`endif
        @(negedge clock);
        reset_n = 1'b1;
        repeat (2) begin
            @(negedge clock);
            check_now({name, "_idle"}, O_IDLE);
        end
    endtask

    task automatic run(input string name);
        bit f;
        build(f);
        play(name);
        if (f) do_reset(name);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        start = 1'b1; full = 1'b1; dry = 1'b1; rinses = 2'd3;
        repeat (3) begin
            @(negedge clock);
            check_now("reset_hold", O_IDLE);
        end
        start = 1'b0;
        reset_n = 1'b1;
        @(negedge clock);
        check_now("reset_release", O_IDLE);
    endtask

    task automatic test_single_pass();
        set_defaults();
        p_fd[0] = 2; p_dd[0] = 1; p_rin_after = 0;
        run("single_pass");
    endtask

    task automatic test_rinses();
        set_defaults();
        p_r = 2; p_rin_after = 0;
        p_fd[0] = 1; p_fd[1] = 0; p_fd[2] = 4;
        p_dd[0] = 0; p_dd[1] = 2; p_dd[2] = 1;
        run("rinses");
    endtask

    task automatic test_fill_timeout();
        set_defaults();
        p_fd[0] = FT; p_fault_cycles = 4;
        run("fill_timeout");
        set_defaults();
        p_r = 1; p_fd[1] = FT + 3;
        run("fill_timeout_pass2");
    endtask

    task automatic test_boundaries();
        set_defaults();
        p_fd[0] = FT - 1;   // full on the timeout cycle wins
        p_sp = SPT - 1;     // dry on the final SPIN cycle
        run("full_on_timeout");
        set_defaults();
        p_sp = 1;
        run("dry_early");
        set_defaults();
        p_sp = 0;
        run("dry_first_spin");
    endtask

    task automatic test_back_to_back();
        set_defaults();
        p_nidle = 0; p_done_start = 1;
        run("back_to_back_a");
        p_r = 1; p_fd[1] = 3;
        run("back_to_back_b");
    endtask

    task automatic test_async_reset();
        bit f;
        set_defaults();
        p_nidle = 0;
        build(f);
        // keep start, one FILL cycle and four SHAKE cycles
        while (trace.size() > 6) void'(trace.pop_back());
        play("async_reset_pre");
        #2;
        check_now("async_reset_in_shake", O_SHAKE);
        reset_n = 1'b0;
        #1;
        check_now("async_reset_drop", O_IDLE);
        start = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        repeat (3) begin
            @(negedge clock);
            check_now("async_reset_idle", O_IDLE);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 40; n++) begin
            set_defaults();
            p_nidle = $urandom_range(0, 2);
            p_r = $urandom_range(0, 3);
            p_done_start = -1;
            for (int i = 0; i < 4; i++) begin
                p_fd[i] = $urandom_range(0, 5);
                if ($urandom_range(9) == 0) p_fd[i] = FT - 1;
                if ($urandom_range(19) == 0) p_fd[i] = FT + $urandom_range(0, 2);
                p_dd[i] = $urandom_range(0, 3);
            end
            p_sp = $urandom_range(0, SPT + 1);
`ifdef WASH_PAUSE_EN
            p_pause_pct = (n % 2 == 0) ? 0 : 20;
`endif
            run("random");
        end
    endtask

`ifdef WASH_PAUSE_EN
    task automatic test_pause();
        set_defaults();
        p_shake_pause = 5;
        run("pause_shake");
        set_defaults();
        p_r = 1; p_fd[0] = 3; p_dd[1] = 2; p_pause_pct = 30;
        run("pause_random");
    endtask
`endif

    initial begin
        test_reset();
        test_single_pass();
        test_rinses();
        test_fill_timeout();
        test_boundaries();
        test_back_to_back();
        test_async_reset();
`ifdef WASH_PAUSE_EN
        test_pause();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
